// File: rtl/clk_count_monitor.sv
// Per-channel frequency monitor: counts synchronized rising edges over a fixed reference window
// and checks each count against programmable limits. Define CLK_MON_STICKY_EN for FAIL_STICKY.
module clk_count_monitor #(
  parameter int unsigned NUM_C         = 4,
  parameter int unsigned EDGE_W        = 16,
  parameter int unsigned WINDOW_CYCLES = 65536
) (
  input  logic                    CLK_IN1,
  input  logic                    COUNTER_RESET,
  input  logic                    ENABLE,
  input  logic [NUM_C-1:0]        COUNT_IN,
  input  logic [NUM_C*EDGE_W-1:0] LIMIT_LO,
  input  logic [NUM_C*EDGE_W-1:0] LIMIT_HI,
  output logic [NUM_C*EDGE_W-1:0] MEAS_DATA,
  output logic                    MEAS_VALID,
  output logic [NUM_C-1:0]        PASS,
  output logic [NUM_C-1:0]        FAIL_STICKY,
  output logic                    BUSY
);

  localparam int unsigned       WinW    = $clog2(WINDOW_CYCLES);
  localparam logic [WinW-1:0]   WinLast = WinW'(WINDOW_CYCLES - 1);
  localparam logic [EDGE_W-1:0] CntMax  = '1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSettle = 2'd1;
  localparam logic [1:0] StRun    = 2'd2;

  logic [1:0]                    state_q, state_d;
  logic [WinW-1:0]               win_cnt_q, win_cnt_d;
  logic [NUM_C-1:0]              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [NUM_C-1:0]              edge_det;
  logic [NUM_C-1:0][EDGE_W-1:0]  edge_cnt_q, edge_cnt_d;
  logic [NUM_C-1:0][EDGE_W-1:0]  closing;
  logic [NUM_C*EDGE_W-1:0]       meas_data_q, meas_data_d;
  logic                          meas_valid_q, meas_valid_d;
  logic [NUM_C-1:0]              pass_q, pass_d;
  logic                          terminal;
  logic                          publish;

  assign edge_det = s2_q & ~s3_q;
  assign terminal = (state_q != StIdle) && (win_cnt_q == WinLast);
  // Only RUN windows are published; the SETTLE window is thrown away.
  assign publish  = terminal && (state_q == StRun);

  always_comb begin
    s1_d = COUNT_IN;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    case (state_q)
      StIdle: begin
        win_cnt_d = '0;
        if (ENABLE) begin
          state_d = StSettle;
        end
      end
      StSettle, StRun: begin
        win_cnt_d = terminal ? '0 : win_cnt_q + WinW'(1);
        if (!ENABLE) begin
          state_d   = StIdle;
          win_cnt_d = '0;
        end else if (terminal) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d   = StIdle;
        win_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_C; i++) begin
      closing[i] = (edge_det[i] && (edge_cnt_q[i] != CntMax)) ? edge_cnt_q[i] + 1'b1
                                                              : edge_cnt_q[i];
      edge_cnt_d[i] = closing[i];
      if ((state_q == StIdle) || terminal || !ENABLE) begin
        edge_cnt_d[i] = '0;
      end
    end
  end

  always_comb begin
    meas_valid_d = publish;
    meas_data_d  = meas_data_q;
    pass_d       = pass_q;
    if (publish) begin
      for (int unsigned i = 0; i < NUM_C; i++) begin
        meas_data_d[i*EDGE_W +: EDGE_W] = closing[i];
        pass_d[i] = (closing[i] >= LIMIT_LO[i*EDGE_W +: EDGE_W]) &&
                    (closing[i] <= LIMIT_HI[i*EDGE_W +: EDGE_W]);
      end
    end
  end

  always_ff @(posedge CLK_IN1) begin
    if (COUNTER_RESET) begin
      state_q      <= StIdle;
      win_cnt_q    <= '0;
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      edge_cnt_q   <= '0;
      meas_data_q  <= '0;
      meas_valid_q <= 1'b0;
      pass_q       <= '0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      edge_cnt_q   <= edge_cnt_d;
      meas_data_q  <= meas_data_d;
      meas_valid_q <= meas_valid_d;
      pass_q       <= pass_d;
    end
  end

`ifdef CLK_MON_STICKY_EN
  logic [NUM_C-1:0] fail_sticky_q, fail_sticky_d;

  always_comb begin
    fail_sticky_d = fail_sticky_q;
    if (publish) begin
      fail_sticky_d = fail_sticky_q | ~pass_d;
    end
  end

  always_ff @(posedge CLK_IN1) begin
    if (COUNTER_RESET) begin
      fail_sticky_q <= '0;
    end else begin
      fail_sticky_q <= fail_sticky_d;
    end
  end

  assign FAIL_STICKY = fail_sticky_q;
`else
  assign FAIL_STICKY = '0;
`endif

  assign MEAS_DATA  = meas_data_q;
  assign MEAS_VALID = meas_valid_q;
  assign PASS       = pass_q;
  assign BUSY       = (state_q != StIdle);

endmodule

// File: tb/tb_clk_count_monitor.sv
// Directed bench for clk_count_monitor: a 1000-cycle-window instance for timing, limits, sticky,
// abort and reset, plus a narrow 4-bit/100-cycle instance for saturation.
module tb_clk_count_monitor;

`ifdef CLK_MON_STICKY_EN
  localparam bit StickyOn = 1'b1;
`else
  localparam bit StickyOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  cin;
  logic [63:0] lo, hi, data;
  logic        mv;
  logic [3:0]  pass, sticky;
  logic        busy;

  logic        sat_en;
  logic [1:0]  sat_in;
  logic [7:0]  sat_lo, sat_hi, sat_data;
  logic        sat_mv;
  logic [1:0]  sat_pass, sat_sticky;
  logic        sat_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0, tm;
  bit seen_mv, seen_busy;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clk_count_monitor #(
    .NUM_C(4), .EDGE_W(16), .WINDOW_CYCLES(1000)
  ) u_dut (
    .CLK_IN1(clk), .COUNTER_RESET(rst), .ENABLE(en), .COUNT_IN(cin),
    .LIMIT_LO(lo), .LIMIT_HI(hi), .MEAS_DATA(data), .MEAS_VALID(mv),
    .PASS(pass), .FAIL_STICKY(sticky), .BUSY(busy)
  );

  clk_count_monitor #(
    .NUM_C(2), .EDGE_W(4), .WINDOW_CYCLES(100)
  ) u_sat (
    .CLK_IN1(clk), .COUNTER_RESET(rst), .ENABLE(sat_en), .COUNT_IN(sat_in),
    .LIMIT_LO(sat_lo), .LIMIT_HI(sat_hi), .MEAS_DATA(sat_data), .MEAS_VALID(sat_mv),
    .PASS(sat_pass), .FAIL_STICKY(sat_sticky), .BUSY(sat_busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_mv(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mv && n < bound);
  endtask

  task automatic wait_sat_mv(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sat_mv && n < bound);
  endtask

  // Channel 1: period 10 cycles; saturation channel 0: period 4 cycles.
  initial begin
    int ph = 0;
    cin    = '0;
    sat_in = '0;
    forever begin
      @(negedge clk);
      ph++;
      if (ph % 5 == 0) cin[1] = ~cin[1];
      if (ph % 2 == 0) sat_in[0] = ~sat_in[0];
    end
  end

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    sat_en = 1'b0;
    lo     = {4{16'd95}};
    hi     = {4{16'd105}};
    sat_lo = {4'd0, 4'd0};
    sat_hi = {4'd15, 4'd15};

    // Reset and idle
    repeat (5) @(negedge clk);
    check("rst_data", data, 64'h0);
    check("rst_valid", mv, 1'b0);
    check("rst_pass", pass, 4'h0);
    check("rst_sticky", sticky, 4'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    seen_mv   = 1'b0;
    seen_busy = 1'b0;
    repeat (5000) begin
      @(negedge clk);
      if (mv) seen_mv = 1'b1;
      if (busy) seen_busy = 1'b1;
    end
    check("idle_no_valid", seen_mv, 1'b0);
    check("idle_no_busy", seen_busy, 1'b0);

    // Nominal
    en = 1'b1;
    t0 = cyc;
    @(negedge clk);
    check("busy_rise", busy, 1'b1);
    wait_mv(2100);
    check("first_valid", mv, 1'b1);
    check("first_latency", cyc - t0, 2001);
    check("nom_data", data, 64'h0000_0000_0064_0000);
    check("nom_pass", pass, 4'b0010);
    check("nom_sticky", sticky, StickyOn ? 4'b1101 : 4'b0000);
    tm = cyc;

    // Limit fail on channel 1
    lo[31:16] = 16'd200;
    hi[31:16] = 16'd300;
    @(negedge clk);
    check("valid_pulse", mv, 1'b0);
    wait_mv(1100);
    check("period", cyc - tm, 1000);
    check("lim_pass", pass, 4'b0000);
    check("lim_sticky", sticky, StickyOn ? 4'b1111 : 4'b0000);
    check("lim_data", data, 64'h0000_0000_0064_0000);

    // Inclusive boundary LO == HI == count
    lo[31:16] = 16'd100;
    hi[31:16] = 16'd100;
    wait_mv(1100);
    check("bound_pass", pass, 4'b0010);

    // LO > HI never passes
    lo[31:16] = 16'd105;
    hi[31:16] = 16'd95;
    wait_mv(1100);
    check("inv_pass", pass, 4'b0000);

    // Recovery: pass returns, sticky keeps the failure
    lo[31:16] = 16'd95;
    hi[31:16] = 16'd105;
    wait_mv(1100);
    check("rec_pass", pass, 4'b0010);
    check("rec_sticky", sticky, StickyOn ? 4'b1111 : 4'b0000);

    // Abort at win_cnt == 500
    repeat (500) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 1'b0);
    seen_mv = mv;
    repeat (1500) begin
      @(negedge clk);
      if (mv) seen_mv = 1'b1;
    end
    check("abort_no_valid", seen_mv, 1'b0);
    check("abort_hold_data", data, 64'h0000_0000_0064_0000);
    check("abort_hold_pass", pass, 4'b0010);
    en = 1'b1;
    t0 = cyc;
    wait_mv(2100);
    check("reen_latency", cyc - t0, 2001);

    // Drop ENABLE on the terminal cycle: measurement still completes
    repeat (999) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check("term_drop_valid", mv, 1'b1);
    check("term_drop_busy", busy, 1'b0);
    @(negedge clk);
    check("term_drop_pulse", mv, 1'b0);

    // Mid-window reset at win_cnt == 700
    en = 1'b1;
    wait_mv(2100);
    repeat (700) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    t0  = cyc;
    check("mrst_data", data, 64'h0);
    check("mrst_pass", pass, 4'h0);
    check("mrst_sticky", sticky, 4'h0);
    check("mrst_busy", busy, 1'b0);
    wait_mv(2100);
    check("mrst_latency", cyc - t0, 2001);
    check("mrst_result", data, 64'h0000_0000_0064_0000);
    check("mrst_sticky2", sticky, StickyOn ? 4'b1101 : 4'b0000);
    en = 1'b0;

    // Saturation: 25 edges in a 4-bit counter
    sat_en = 1'b1;
    t0 = cyc;
    wait_sat_mv(300);
    check("sat_latency", cyc - t0, 201);
    check("sat_data", sat_data, 8'h0F);
    check("sat_pass", sat_pass, 2'b11);
    sat_hi[3:0] = 4'd14;
    wait_sat_mv(150);
    check("sat_hi14_pass", sat_pass, 2'b10);
    check("sat_sticky", sat_sticky, StickyOn ? 2'b01 : 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_count_monitor.md
# clk_count_monitor

Frequency monitor that sits directly downstream of the clocking-network example design and consumes its per-clock counter high bits (`COUNT[4:1]`). Each bit toggles at a rate proportional to its generated clock. The block synchronizes each bit into the reference clock domain, counts rising edges over a fixed window of reference cycles, and publishes the per-channel counts with pass/fail checks against programmable limits. Its results are the observable self-check of the clocking network on the board.

## Interface
Parameters:
- `NUM_C`, 4: number of monitored channels.
- `EDGE_W`, 16: width of each per-channel edge count.
- `WINDOW_CYCLES`, 65536: reference cycles per measurement window; legal range 2..2^24.

Ports:
- `CLK_IN1`  in  1  reference clock; the only clock in the block.
- `COUNTER_RESET`  in  1  synchronous, active-high reset.
- `ENABLE`  in  1  level; 1 runs measurements, 0 returns to IDLE.
- `COUNT_IN`  in  NUM_C  asynchronous toggle inputs, fed from upstream `COUNT`.
- `LIMIT_LO`  in  NUM_C*EDGE_W  per-channel minimum acceptable count; channel i occupies bits [i*EDGE_W +: EDGE_W].
- `LIMIT_HI`  in  NUM_C*EDGE_W  per-channel maximum acceptable count; same packing as `LIMIT_LO`.
- `MEAS_DATA`  out  NUM_C*EDGE_W  edge counts from the last completed window.
- `MEAS_VALID`  out  1  one-cycle pulse when `MEAS_DATA` and `PASS` update.
- `PASS`  out  NUM_C  1 when the last count satisfies LO ≤ count ≤ HI.
- `FAIL_STICKY`  out  NUM_C  latched failure flags.
- `BUSY`  out  1  1 in SETTLE or RUN.

## Operation
- Per channel: 3-flop synchronizer (s1→s2→s3); rising edge = s2 & ~s3.
- FSM states: IDLE, SETTLE, RUN.
  - IDLE: `win_cnt` and edge counters held at 0.
  - IDLE→SETTLE when `ENABLE`=1.
  - SETTLE→RUN at the window terminal cycle. The SETTLE window is discarded; upstream counters may still be emerging from their reset.
  - RUN: stays in RUN, one measurement per window.
  - SETTLE or RUN → IDLE when `ENABLE`=0. The in-progress window is dropped: no `MEAS_VALID`, outputs hold their values.
- `win_cnt` counts 0..WINDOW_CYCLES-1 and wraps to 0. The terminal cycle is `win_cnt`==WINDOW_CYCLES-1.
- Edge counters increment on a detected edge and saturate at 2^EDGE_W-1; they never wrap.
- Terminal cycle in RUN, per channel:
  - The closing count (including an edge detected in this cycle) is registered to `MEAS_DATA`.
  - `PASS` is computed from the same closing value using unsigned compares.
  - The edge counter clears to 0.
- `FAIL_STICKY[i]` is set when `MEAS_VALID` fires with `PASS[i]`=0. It is cleared only by `COUNTER_RESET`.
- If LO > HI for a channel, `PASS[i]` is always 0.
- Limits are sampled only at the terminal cycle; they may change at any time.

## Timing
- Reset values: `MEAS_DATA`=0, `MEAS_VALID`=0, `PASS`=0, `FAIL_STICKY`=0, `BUSY`=0, FSM=IDLE, all synchronizer flops=0.
- `COUNTER_RESET` has priority over everything, including mid-window. The next measurement requires a fresh SETTLE window.
- Input edge to edge-detect: 2 cycles after capture by s1. To count, an edge must reach detect no later than the terminal cycle; otherwise it lands in the next window.
- `ENABLE` rising to `BUSY`=1: 1 cycle.
- First `MEAS_VALID` occurs 2*WINDOW_CYCLES+1 cycles after `ENABLE` rises; thereafter it repeats every WINDOW_CYCLES cycles.
- `MEAS_VALID` is high in the cycle after the terminal cycle. `MEAS_DATA`, `PASS` and `FAIL_STICKY` update on that same edge.
- Dropping `ENABLE` on the terminal cycle completes that measurement: `MEAS_VALID` fires, then the FSM goes to IDLE.
- Inputs must toggle at less than half the `CLK_IN1` rate; faster toggling yields undercount, which is not detected.

## Configuration
- `CLK_MON_STICKY_EN`
  - Defined: `FAIL_STICKY` logic is built as described.
  - Undefined: no sticky registers are built, and `FAIL_STICKY` is tied to 0.

## Test plan
- Reset and idle: hold `COUNTER_RESET` 5 cycles with `ENABLE`=0 and `COUNT_IN` toggling → all outputs 0, `BUSY`=0, no `MEAS_VALID` for 5000 cycles.
- Nominal: `WINDOW_CYCLES`=1000; `COUNT_IN[1]` square wave, period 10 cycles; LO=95, HI=105 → first `MEAS_VALID` at cycle 2001 after `ENABLE`, count 100±1, `PASS[1]`=1. Channels held static → count 0, `PASS`=0 with LO=95.
- Limit fail and sticky: same stimulus with LO=200, HI=300 → `PASS[1]`=0 and `FAIL_STICKY[1]`=1. After changing LO to 95, the next window gives `PASS[1]`=1 while `FAIL_STICKY[1]` stays 1 (macro defined) or reads 0 (macro undefined).
- Saturation: `EDGE_W`=4, `WINDOW_CYCLES`=100, period 4 (25 edges) → count 15 and not wrapped; HI=15 → `PASS`=1.
- Abort: drop `ENABLE` at `win_cnt`=500 in RUN → no `MEAS_VALID`, `BUSY`=0 next cycle, outputs hold. Re-enable → a full SETTLE window precedes the next `MEAS_VALID`.
- Mid-window reset: assert `COUNTER_RESET` for one cycle at `win_cnt`=700 → all outputs return to reset values. The `ENABLE`=1 restart follows the 2*WINDOW_CYCLES+1 latency.
